// File: rtl/dist_fifo_if.sv
// Producer/consumer handshake plus distributed-RAM port bundle for dist_fifo_ctrl.
// The almost_full flag exists only when DIST_FIFO_AF_EN is defined.
interface dist_fifo_if #(
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 4
);
    logic                     s_valid;
    logic                     s_ready;
    logic [DATA_BITWIDTH-1:0] s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_BITWIDTH-1:0] m_data;
    logic                     ram_we;
    logic [ADDR_BITWIDTH-1:0] ram_a;
    logic [DATA_BITWIDTH-1:0] ram_di;
    logic [ADDR_BITWIDTH-1:0] ram_dpra;
    logic [DATA_BITWIDTH-1:0] ram_dpo;
    logic [ADDR_BITWIDTH:0]   count;
    logic                     full;
    logic                     empty;
`ifdef DIST_FIFO_AF_EN
    logic                     almost_full;
`endif

    // Controller side
    modport slave (
        input  s_valid, s_data, m_ready, ram_dpo,
        output s_ready, m_valid, m_data, ram_we, ram_a, ram_di, ram_dpra,
               count, full, empty
`ifdef DIST_FIFO_AF_EN
        , output almost_full
`endif
    );

    // Producer/consumer/RAM side
    modport master (
        output s_valid, s_data, m_ready, ram_dpo,
        input  s_ready, m_valid, m_data, ram_we, ram_a, ram_di, ram_dpra,
               count, full, empty
`ifdef DIST_FIFO_AF_EN
        , input almost_full
`endif
    );
endinterface

// File: rtl/dist_fifo_ctrl.sv
// First-word-fall-through FIFO controller sequencing an external dual-port distributed RAM.
// Optional registered almost_full flag enabled by defining DIST_FIFO_AF_EN.
module dist_fifo_ctrl #(
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 4
`ifdef DIST_FIFO_AF_EN
    ,
    parameter int AF_THRESH = (1 << ADDR_BITWIDTH) - 2
`endif
) (
    input logic        clk,
    input logic        rst,
    input logic        clr,
    dist_fifo_if.slave bus
);
    localparam int                     DEPTH   = 1 << ADDR_BITWIDTH;
    localparam logic [ADDR_BITWIDTH:0] DEPTH_C = DEPTH[ADDR_BITWIDTH:0];
`ifdef DIST_FIFO_AF_EN
    localparam logic [ADDR_BITWIDTH:0] AF_LVL_C = AF_THRESH[ADDR_BITWIDTH:0];
`endif

    logic [ADDR_BITWIDTH-1:0] wr_ptr_r;
    logic [ADDR_BITWIDTH-1:0] rd_ptr_r;
    logic [ADDR_BITWIDTH:0]   count_r;
    logic                     full_r;
    logic                     empty_r;
    logic [ADDR_BITWIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_BITWIDTH-1:0] rd_ptr_nxt_s;
    logic [ADDR_BITWIDTH:0]   count_nxt_s;
    logic                     s_ready_s;
    logic                     m_valid_s;
    logic                     push_s;
    logic                     pop_s;
    logic [DATA_BITWIDTH-1:0] wr_data_s;
    logic [DATA_BITWIDTH-1:0] head_data_s;
`ifdef DIST_FIFO_AF_EN
    logic                     almost_full_r;
`endif

    // Handshake gating: rst/clr block both sides so clr always wins over a push/pop
    assign s_ready_s   = !full_r && !rst && !clr;
    assign m_valid_s   = !empty_r && !rst && !clr;
    assign push_s      = bus.s_valid && s_ready_s;
    assign pop_s       = m_valid_s && bus.m_ready;
    assign wr_data_s   = bus.s_data;
    assign head_data_s = bus.ram_dpo;

    assign bus.s_ready  = s_ready_s;
    assign bus.m_valid  = m_valid_s;
    assign bus.m_data   = head_data_s;
    assign bus.ram_we   = push_s;
    assign bus.ram_a    = wr_ptr_r;
    assign bus.ram_di   = wr_data_s;
    assign bus.ram_dpra = rd_ptr_r;
    assign bus.count    = count_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
`ifdef DIST_FIFO_AF_EN
    assign bus.almost_full = almost_full_r;
`endif

    // Next-state pointers and occupancy
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + ADDR_BITWIDTH'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + ADDR_BITWIDTH'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (ADDR_BITWIDTH+1)'(1);
            2'b01:   count_nxt_s = count_r - (ADDR_BITWIDTH+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // State and flag registers; flags decode the next count so they align with count_r
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_C);
            empty_r  <= (count_nxt_s == '0);
        end
    end

`ifdef DIST_FIFO_AF_EN
    // Almost-full flag evaluated on the next-state count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            almost_full_r <= 1'b0;
        end else begin
            almost_full_r <= (count_nxt_s >= AF_LVL_C);
        end
    end
`endif
endmodule

// File: tb/tb_dist_fifo_ctrl.sv
// Table-driven bench for dist_fifo_ctrl with D=4 and a behavioural distributed RAM.
module tb_dist_fifo_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dist_fifo_if #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(2)) bus ();

`ifdef DIST_FIFO_AF_EN
    dist_fifo_ctrl #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(2), .AF_THRESH(3)) dut (
`else
    dist_fifo_ctrl #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(2)) dut (
`endif
        .clk(clk), .rst(rst), .clr(clr), .bus(bus)
    );

    logic [7:0] mem [4];
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_di;
    assign bus.ram_dpo = mem[bus.ram_dpra];

    typedef struct {
        logic [2:0] ctl;   // rst, clr, s_valid
        logic [7:0] sd;
        logic       mr;
        logic [1:0] hs;    // s_ready, m_valid
        logic [7:0] md;
        logic       we;
        logic [1:0] wa;
        logic [1:0] ra;
        logic [2:0] cnt;
        logic [2:0] fea;   // full, empty, almost_full
    } vec_t;

    vec_t vecs [34];

    function automatic vec_t mk(input logic [2:0] ctl, input logic [7:0] sd, input logic mr,
                                input logic [1:0] hs, input logic [7:0] md, input logic we,
                                input logic [1:0] wa, input logic [1:0] ra, input logic [2:0] cnt,
                                input logic [2:0] fea);
        vec_t v;
        v.ctl = ctl; v.sd = sd; v.mr = mr; v.hs = hs; v.md = md;
        v.we = we; v.wa = wa; v.ra = ra; v.cnt = cnt; v.fea = fea;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual=%0h required=%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic sv, input logic [7:0] sd, input logic mr);
        rst = r; clr = c; bus.s_valid = sv; bus.s_data = sd; bus.m_ready = mr;
    endtask

    initial begin
        int accepted;
        int popped;
        logic [7:0] exp_q [$];
        logic [7:0] exp_w;

        //              rst/clr/sv  sd     mr    sr/mv  md     we    wa    ra    cnt   full/empty/af
        vecs[0]  = mk(3'b101, 8'hAA, 1'b0, 2'b00, 8'h00, 1'b0, 2'd0, 2'd0, 3'd0, 3'b010);
        vecs[1]  = mk(3'b000, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 2'd0, 2'd0, 3'd0, 3'b010);
        vecs[2]  = mk(3'b001, 8'h11, 1'b0, 2'b10, 8'h00, 1'b1, 2'd0, 2'd0, 3'd0, 3'b010);
        vecs[3]  = mk(3'b001, 8'h22, 1'b0, 2'b11, 8'h11, 1'b1, 2'd1, 2'd0, 3'd1, 3'b000);
        vecs[4]  = mk(3'b001, 8'h33, 1'b0, 2'b11, 8'h11, 1'b1, 2'd2, 2'd0, 3'd2, 3'b000);
        vecs[5]  = mk(3'b001, 8'h44, 1'b0, 2'b11, 8'h11, 1'b1, 2'd3, 2'd0, 3'd3, 3'b001);
        vecs[6]  = mk(3'b001, 8'h55, 1'b0, 2'b01, 8'h11, 1'b0, 2'd0, 2'd0, 3'd4, 3'b101);
        vecs[7]  = mk(3'b000, 8'h00, 1'b1, 2'b01, 8'h11, 1'b0, 2'd0, 2'd0, 3'd4, 3'b101);
        vecs[8]  = mk(3'b000, 8'h00, 1'b1, 2'b11, 8'h22, 1'b0, 2'd0, 2'd1, 3'd3, 3'b001);
        vecs[9]  = mk(3'b000, 8'h00, 1'b1, 2'b11, 8'h33, 1'b0, 2'd0, 2'd2, 3'd2, 3'b000);
        vecs[10] = mk(3'b000, 8'h00, 1'b1, 2'b11, 8'h44, 1'b0, 2'd0, 2'd3, 3'd1, 3'b000);
        vecs[11] = mk(3'b000, 8'h00, 1'b1, 2'b10, 8'h00, 1'b0, 2'd0, 2'd0, 3'd0, 3'b010);
        vecs[12] = mk(3'b001, 8'hA0, 1'b1, 2'b10, 8'h00, 1'b1, 2'd0, 2'd0, 3'd0, 3'b010);
        vecs[13] = mk(3'b001, 8'hA1, 1'b1, 2'b11, 8'hA0, 1'b1, 2'd1, 2'd0, 3'd1, 3'b000);
        vecs[14] = mk(3'b001, 8'hA2, 1'b1, 2'b11, 8'hA1, 1'b1, 2'd2, 2'd1, 3'd1, 3'b000);
        vecs[15] = mk(3'b001, 8'hA3, 1'b1, 2'b11, 8'hA2, 1'b1, 2'd3, 2'd2, 3'd1, 3'b000);
        vecs[16] = mk(3'b001, 8'hA4, 1'b1, 2'b11, 8'hA3, 1'b1, 2'd0, 2'd3, 3'd1, 3'b000);
        vecs[17] = mk(3'b001, 8'hA5, 1'b1, 2'b11, 8'hA4, 1'b1, 2'd1, 2'd0, 3'd1, 3'b000);
        vecs[18] = mk(3'b000, 8'h00, 1'b1, 2'b11, 8'hA5, 1'b0, 2'd2, 2'd1, 3'd1, 3'b000);
        vecs[19] = mk(3'b000, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 2'd2, 2'd2, 3'd0, 3'b010);
        vecs[20] = mk(3'b001, 8'hB0, 1'b0, 2'b10, 8'h00, 1'b1, 2'd2, 2'd2, 3'd0, 3'b010);
        vecs[21] = mk(3'b001, 8'hB1, 1'b0, 2'b11, 8'hB0, 1'b1, 2'd3, 2'd2, 3'd1, 3'b000);
        vecs[22] = mk(3'b001, 8'hB2, 1'b1, 2'b11, 8'hB0, 1'b1, 2'd0, 2'd2, 3'd2, 3'b000);
        vecs[23] = mk(3'b001, 8'hB3, 1'b0, 2'b11, 8'hB1, 1'b1, 2'd1, 2'd3, 3'd2, 3'b000);
        vecs[24] = mk(3'b001, 8'hB4, 1'b0, 2'b11, 8'hB1, 1'b1, 2'd2, 2'd3, 3'd3, 3'b001);
        vecs[25] = mk(3'b001, 8'hC0, 1'b1, 2'b01, 8'hB1, 1'b0, 2'd3, 2'd3, 3'd4, 3'b101);
        vecs[26] = mk(3'b000, 8'h00, 1'b0, 2'b11, 8'hB2, 1'b0, 2'd3, 2'd0, 3'd3, 3'b001);
        vecs[27] = mk(3'b011, 8'hD0, 1'b1, 2'b00, 8'h00, 1'b0, 2'd3, 2'd0, 3'd3, 3'b001);
        vecs[28] = mk(3'b000, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 2'd0, 2'd0, 3'd0, 3'b010);
        vecs[29] = mk(3'b001, 8'hE0, 1'b0, 2'b10, 8'h00, 1'b1, 2'd0, 2'd0, 3'd0, 3'b010);
        vecs[30] = mk(3'b001, 8'hE1, 1'b0, 2'b11, 8'hE0, 1'b1, 2'd1, 2'd0, 3'd1, 3'b000);
        vecs[31] = mk(3'b001, 8'hE2, 1'b0, 2'b11, 8'hE0, 1'b1, 2'd2, 2'd0, 3'd2, 3'b000);
        vecs[32] = mk(3'b101, 8'hF0, 1'b1, 2'b00, 8'h00, 1'b0, 2'd3, 2'd0, 3'd3, 3'b001);
        vecs[33] = mk(3'b000, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 2'd0, 2'd0, 3'd0, 3'b010);

        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;

        // Each row: drive inputs, settle, check, then take the edge
        for (int i = 0; i < 34; i++) begin
            drive(vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].sd, vecs[i].mr);
            #1;
            chk("s_ready",  i, 32'(bus.s_ready),  32'(vecs[i].hs[1]));
            chk("m_valid",  i, 32'(bus.m_valid),  32'(vecs[i].hs[0]));
            if (vecs[i].hs[0]) chk("m_data", i, 32'(bus.m_data), 32'(vecs[i].md));
            chk("ram_we",   i, 32'(bus.ram_we),   32'(vecs[i].we));
            chk("ram_a",    i, 32'(bus.ram_a),    32'(vecs[i].wa));
            chk("ram_di",   i, 32'(bus.ram_di),   32'(vecs[i].sd));
            chk("ram_dpra", i, 32'(bus.ram_dpra), 32'(vecs[i].ra));
            chk("count",    i, 32'(bus.count),    32'(vecs[i].cnt));
            chk("full",     i, 32'(bus.full),     32'(vecs[i].fea[2]));
            chk("empty",    i, 32'(bus.empty),    32'(vecs[i].fea[1]));
`ifdef DIST_FIFO_AF_EN
            chk("almost_full", i, 32'(bus.almost_full), 32'(vecs[i].fea[0]));
`endif
            @(posedge clk); #1;
        end

        // Hand sequence: push with a bounded budget until the queue refuses, then drain
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            exp_w = 8'h60 + 8'(accepted);
            drive(1'b0, 1'b0, 1'b1, exp_w, 1'b0);
            #1;
            if (bus.s_ready) begin
                exp_q.push_back(exp_w);
                accepted++;
            end
            @(posedge clk); #1;
        end
        chk("fill_accepted", 100, 32'(accepted), 32'd4);
        chk("fill_full", 100, 32'(bus.full), 32'd1);

        popped = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            #1;
            if (bus.m_valid) begin
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    chk("drain_data", 101 + popped, 32'(bus.m_data), 32'(exp_w));
                end else begin
                    chk("drain_extra", 101 + popped, 32'd1, 32'd0);
                end
                popped++;
            end
            @(posedge clk); #1;
        end
        chk("drain_popped", 110, 32'(popped), 32'd4);
        chk("drain_empty", 110, 32'(bus.empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dist_fifo_ctrl.md
# dist_fifo_ctrl

First-in-first-out (FIFO) pointer and flag controller that sequences one dual-port distributed RAM as a first-word-fall-through queue. The RAM's write/`spo` port carries pushes and its `dpra`/`dpo` port carries pops, so data and storage stay in the RAM. The block sits between a producer and a consumer on the valid/ready handshake. It drives the RAM's `we`, `a`, `di` and `dpra` inputs and returns the RAM's `dpo` as output data.

## Interface
- `DATA_BITWIDTH`, default 8: data word width. Must match the attached RAM.
- `ADDR_BITWIDTH`, default 4: RAM address width. Depth D = 2^ADDR_BITWIDTH.
- `AF_THRESH`, default 2^ADDR_BITWIDTH-2: almost-full level. Used only with `DIST_FIFO_AF_EN`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous flush. Pointers and count return to 0.
- `s_valid` in 1: producer has a word.
- `s_ready` out 1: a push is accepted when this is 1.
- `s_data` in DATA_BITWIDTH: push data.
- `m_valid` out 1: head word present.
- `m_ready` in 1: consumer takes the head word.
- `m_data` out DATA_BITWIDTH: head word. Wired directly from `ram_dpo`.
- `ram_we` out 1: RAM write enable.
- `ram_a` out ADDR_BITWIDTH: RAM write address, equal to `wr_ptr`.
- `ram_di` out DATA_BITWIDTH: RAM write data, equal to `s_data`.
- `ram_dpra` out ADDR_BITWIDTH: RAM read address, equal to `rd_ptr`.
- `ram_dpo` in DATA_BITWIDTH: RAM asynchronous read data.
- `count` out ADDR_BITWIDTH+1: occupancy, from 0 to D.
- `full` out 1: count == D.
- `empty` out 1: count == 0.
- `almost_full` out 1: present only with `DIST_FIFO_AF_EN`.

## Operation
- State:
  - `wr_ptr` and `rd_ptr`: ADDR_BITWIDTH bits each, natural wrap from D-1 to 0.
  - `count`: ADDR_BITWIDTH+1 bits.
- Handshake signals:
  - `s_ready = !full && !rst && !clr`.
  - `m_valid = !empty && !rst && !clr`.
- push = `s_valid && s_ready`. pop = `m_valid && m_ready`.
- Write path is combinational: `ram_we = push`, `ram_a = wr_ptr`, `ram_di = s_data`.
- On push: `wr_ptr` increments by 1 (mod D).
- On pop: `rd_ptr` increments by 1 (mod D).
- `count` update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push and pop together.
- Full: `s_ready` = 0 even if a pop occurs in the same cycle. There is no push-through-on-pop.
- Empty: `m_valid` = 0 and there is no bypass. A pushed word is never visible in its push cycle.
- `full` and `empty` are decoded from the registered `count`. Pointers never collide while count is in range.
- `clr` has priority over push and pop in the same cycle. The word offered in that cycle is not written (`ram_we` = 0).
- `rst` has priority over `clr`.
- Reset or clear in the middle of operation discards the queued words. RAM contents are not cleared; stale data is unreachable because `m_valid` = 0.
- The handshakes are protocol-clean: no output depends on `s_valid` or `m_ready` except `ram_we`.

## Timing
- Reset values:
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `m_valid` = 0.
  - `s_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` deasserts.
  - `almost_full` = 0.
- Push-to-visible latency is 1 cycle. A push accepted at edge N gives `m_valid` = 1 and `m_data` = that word in the cycle after edge N.
- Pop takes effect at the edge. The next word appears on `m_data` in the following cycle through the asynchronous `dpo`.
- `full` and `s_ready` update on the edge after the D-th push. `empty` updates on the edge after the last pop.
- Sustained simultaneous push and pop at 1 word per cycle is supported whenever 0 < count < D.

## Configuration
- `DIST_FIFO_AF_EN`:
  - Defined: adds output `almost_full`, a registered flag equal to `count >= AF_THRESH` evaluated on the next-state count, so it is valid in the same cycle as `count`.
  - Undefined: the port and its logic are absent, and `AF_THRESH` is ignored.

## Test plan
- Bench settings: ADDR_BITWIDTH=2 (D=4), DATA_BITWIDTH=8, `m_ready`=0 unless stated.
- Reset then idle:
  - Required during reset: `s_ready`=0, `m_valid`=0, `empty`=1, `count`=0.
  - After `rst` falls: `s_ready`=1 next cycle.
- Fill to full:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44.
  - Required: `ram_a` = 0,1,2,3; `count` = 4; `full`=1; `s_ready`=0; a fifth `s_valid` gives `ram_we`=0.
- Drain in order:
  - Stimulus: from full, hold `m_ready`=1.
  - Required: `m_data` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles; then `empty`=1 and `m_valid`=0.
- Wrap and steady state:
  - Stimulus: push 6 words with `m_ready`=1 held.
  - Required: `wr_ptr` wraps 3→0; `count` stays at 1 after the first push; output order is preserved.
- Simultaneous events:
  - At count=2, push and pop together: count stays 2.
  - At count=4 with `s_valid`=1 and `m_ready`=1: pop only, count=3.
  - At count=0 with push: `m_valid` stays 0 that cycle.
- Clear and reset mid-operation:
  - Stimulus: at count=3, assert `clr` together with `s_valid`.
  - Required: next cycle `count`=0, `empty`=1, and no write occurred (`ram_we`=0 during the `clr` cycle).
  - Repeat the same check with `rst` in place of `clr`.
- `DIST_FIFO_AF_EN` defined, AF_THRESH=3:
  - Required: `almost_full` rises in the same cycle `count` reaches 3 and falls when `count` returns to 2.
